// File: rtl/xorshift32_pkg.sv
// Shared types and constants for the xorshift32 request arbiter.
package xorshift32_pkg;

    localparam int RNG_W = 32;
    localparam logic [RNG_W-1:0] PKG_DEFAULT_SEED = 32'h1234_5678;

    typedef enum logic [1:0] {
        ST_SEED   = 2'd0,
        ST_SETTLE = 2'd1,
        ST_RUN    = 2'd2,
        ST_LOAD   = 2'd3
    } state_t;

    // An all-zero seed would lock xorshift at zero forever, so swap in the fallback.
    function automatic logic [RNG_W-1:0] safe_seed(input logic [RNG_W-1:0] val,
                                                   input logic [RNG_W-1:0] dflt);
        return (val == {RNG_W{1'b0}}) ? dflt : val;
    endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Round-robin arbiter: one-hot grant to the first request at or above ptr, wrapping.
module rr_arbiter
    import xorshift32_pkg::*;
#(
    parameter int NUM_REQ = 4,
    parameter int PTR_W   = $clog2(NUM_REQ)
) (
    input  logic [NUM_REQ-1:0] req,
    input  logic [PTR_W-1:0]   ptr,
    output logic [NUM_REQ-1:0] grant
);

    int               idx_s;
    logic [PTR_W-1:0] sel_s;
    logic             hit_s;
    logic             found_s;

    // Walk the requesters starting at ptr; the first hit wins.
    always_comb begin
        grant   = {NUM_REQ{1'b0}};
        found_s = 1'b0;
        idx_s   = 0;
        sel_s   = {PTR_W{1'b0}};
        hit_s   = 1'b0;
        for (int off = 0; off < NUM_REQ; off++) begin
            idx_s        = int'(ptr) + off;
            idx_s        = (idx_s >= NUM_REQ) ? (idx_s - NUM_REQ) : idx_s;
            sel_s        = idx_s[PTR_W-1:0];
            hit_s        = req[sel_s] && !found_s;
            grant[sel_s] = grant[sel_s] | hit_s;
            found_s      = found_s | hit_s;
        end
    end

endmodule

// File: rtl/xorshift32_arb.sv
// Shares one external xorshift32 generator among NUM_REQ requesters, with reseed sequencing.
// Optional macro XORSHIFT32_ARB_STATS_EN adds per-requester saturating grant counters.
module xorshift32_arb
    import xorshift32_pkg::*;
#(
    parameter int               NUM_REQ       = 4,
    parameter logic [RNG_W-1:0] DEFAULT_SEED  = PKG_DEFAULT_SEED,
    parameter int               SETTLE_CYCLES = 2
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic [NUM_REQ-1:0]         req_valid,
    output logic [NUM_REQ-1:0]         req_ready,
    output logic [NUM_REQ-1:0]         rsp_valid,
    output logic [RNG_W-1:0]           rsp_data,
    input  logic                       reseed_req,
    input  logic [RNG_W-1:0]           reseed_val,
    output logic                       busy,
    output logic [RNG_W-1:0]           gen_seed,
    output logic                       gen_re_seed,
    input  logic [RNG_W-1:0]           gen_rnd,
    input  logic [$clog2(NUM_REQ)-1:0] stat_sel,
    output logic [15:0]                stat_cnt
);

    localparam int               PTR_W       = $clog2(NUM_REQ);
    localparam int               CNT_W       = 4;
    localparam logic [CNT_W-1:0] SETTLE_LAST = CNT_W'(SETTLE_CYCLES - 1);

    state_t             state_r;
    state_t             state_next_s;
    logic [PTR_W-1:0]   ptr_r;
    logic [PTR_W-1:0]   ptr_next_s;
    logic [CNT_W-1:0]   settle_cnt_r;
    logic [RNG_W-1:0]   seed_r;
    logic [RNG_W-1:0]   rsp_data_r;
    logic [NUM_REQ-1:0] rsp_valid_r;
    logic [NUM_REQ-1:0] grant_s;
    logic [NUM_REQ-1:0] ready_s;
    logic [NUM_REQ-1:0] xfer_s;
    logic               re_seed_r;
    logic               busy_r;
    logic               run_s;
    logic               reseed_take_s;

    rr_arbiter #(.NUM_REQ(NUM_REQ), .PTR_W(PTR_W)) u_rr (
        .req   (req_valid),
        .ptr   (ptr_r),
        .grant (grant_s)
    );

    // Grants only in RUN, and a same-cycle reseed suppresses them.
    always_comb begin
        run_s         = (state_r == ST_RUN);
        reseed_take_s = run_s && reseed_req;
        ready_s       = (run_s && !reseed_req) ? grant_s : {NUM_REQ{1'b0}};
        xfer_s        = ready_s & req_valid;
    end

    // Pointer advances to one past the granted requester; unchanged otherwise.
    always_comb begin
        ptr_next_s = ptr_r;
        for (int i = 0; i < NUM_REQ; i++) begin
            ptr_next_s = xfer_s[i] ? ((i == NUM_REQ - 1) ? {PTR_W{1'b0}} : PTR_W'(i + 1))
                                   : ptr_next_s;
        end
    end

    // Next-state logic; LOAD is never entered and falls back to SEED if reached.
    always_comb begin
        state_next_s = state_r;
        case (state_r)
            ST_SEED:   state_next_s = ST_SETTLE;
            ST_SETTLE: state_next_s = (settle_cnt_r == SETTLE_LAST) ? ST_RUN : ST_SETTLE;
            ST_RUN:    state_next_s = reseed_req ? ST_SEED : ST_RUN;
            ST_LOAD:   state_next_s = ST_SEED;
            default:   state_next_s = ST_SEED;
        endcase
    end

    // Control registers: state, pointer, settle counter, seed, reseed pulse, busy.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_r      <= ST_SEED;
            ptr_r        <= {PTR_W{1'b0}};
            settle_cnt_r <= {CNT_W{1'b0}};
            seed_r       <= DEFAULT_SEED;
            re_seed_r    <= 1'b0;
            busy_r       <= 1'b1;
        end else begin
            state_r      <= state_next_s;
            ptr_r        <= ptr_next_s;
            settle_cnt_r <= ((state_r == ST_SETTLE) && (state_next_s == ST_SETTLE))
                            ? (settle_cnt_r + 4'd1) : {CNT_W{1'b0}};
            seed_r       <= reseed_take_s ? safe_seed(reseed_val, DEFAULT_SEED) : seed_r;
            re_seed_r    <= (state_r == ST_SEED);
            busy_r       <= (state_next_s != ST_RUN);
        end
    end

    // Response strobe and data; data holds between transfers.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            rsp_valid_r <= {NUM_REQ{1'b0}};
            rsp_data_r  <= {RNG_W{1'b0}};
        end else begin
            rsp_valid_r <= xfer_s;
            rsp_data_r  <= (|xfer_s) ? gen_rnd : rsp_data_r;
        end
    end

`ifdef XORSHIFT32_ARB_STATS_EN
    logic [15:0] stat_r [NUM_REQ];

    // Saturating per-requester grant counters.
    always_ff @(posedge clk) begin
        for (int i = 0; i < NUM_REQ; i++) begin
            if (!rst_n) begin
                stat_r[i] <= 16'd0;
            end else begin
                stat_r[i] <= (xfer_s[i] && (stat_r[i] != 16'hFFFF)) ? (stat_r[i] + 16'd1) : stat_r[i];
            end
        end
    end

    // Statistics read port.
    always_comb begin
        stat_cnt = (int'(stat_sel) < NUM_REQ) ? stat_r[stat_sel] : 16'd0;
    end
`else
    logic unused_stat_sel_s;
    assign unused_stat_sel_s = ^stat_sel;
    assign stat_cnt          = 16'd0;
`endif

    assign req_ready   = ready_s;
    assign rsp_valid   = rsp_valid_r;
    assign rsp_data    = rsp_data_r;
    assign busy        = busy_r;
    assign gen_seed    = seed_r;
    assign gen_re_seed = re_seed_r;

endmodule

// File: tb/tb_xorshift32_arb.sv
// Directed, table-driven bench for xorshift32_arb with a behavioural xorshift32 generator.
module tb_xorshift32_arb;

    localparam int N = 4;

    logic          clk = 1'b0;
    logic          rst_n;
    logic [N-1:0]  req_valid;
    logic [N-1:0]  req_ready;
    logic [N-1:0]  rsp_valid;
    logic [31:0]   rsp_data;
    logic          reseed_req;
    logic [31:0]   reseed_val;
    logic          busy;
    logic [31:0]   gen_seed;
    logic          gen_re_seed;
    logic [31:0]   gen_rnd;
    logic [1:0]    stat_sel;
    logic [15:0]   stat_cnt;
    logic [31:0]   g_state;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    xorshift32_arb #(
        .NUM_REQ       (N),
        .DEFAULT_SEED  (32'h1234_5678),
        .SETTLE_CYCLES (2)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .req_valid   (req_valid),
        .req_ready   (req_ready),
        .rsp_valid   (rsp_valid),
        .rsp_data    (rsp_data),
        .reseed_req  (reseed_req),
        .reseed_val  (reseed_val),
        .busy        (busy),
        .gen_seed    (gen_seed),
        .gen_re_seed (gen_re_seed),
        .gen_rnd     (gen_rnd),
        .stat_sel    (stat_sel),
        .stat_cnt    (stat_cnt)
    );

    function automatic logic [31:0] xs(input logic [31:0] x);
        logic [31:0] y;
        y = x;
        y = y ^ (y << 13);
        y = y ^ (y >> 17);
        y = y ^ (y << 5);
        return y;
    endfunction

    // Generator model: loads seed on re_seed, otherwise steps; rnd is the state.
    always @(posedge clk) g_state <= gen_re_seed ? gen_seed : xs(g_state);
    assign gen_rnd = g_state;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_run(input string name);
        int n;
        n = 0;
        while (busy && n < 20) begin
            tick();
            n++;
        end
        check(name, {31'd0, busy}, 32'd0);
    endtask

    typedef struct {
        logic [N-1:0] valid;
        logic [N-1:0] ready;
    } vec_t;

    vec_t         tbl [15];
    logic [N-1:0] grant_v;
    logic [31:0]  exp_data;
    logic [31:0]  exp_word;

    initial begin
        tbl[0]  = '{4'b1111, 4'b0001};
        tbl[1]  = '{4'b1111, 4'b0010};
        tbl[2]  = '{4'b1111, 4'b0100};
        tbl[3]  = '{4'b1111, 4'b1000};
        tbl[4]  = '{4'b1111, 4'b0001};
        tbl[5]  = '{4'b1010, 4'b0010};
        tbl[6]  = '{4'b1010, 4'b1000};
        tbl[7]  = '{4'b1010, 4'b0010};
        tbl[8]  = '{4'b1010, 4'b1000};
        tbl[9]  = '{4'b0000, 4'b0000};
        tbl[10] = '{4'b0100, 4'b0100};
        tbl[11] = '{4'b0001, 4'b0001};
        tbl[12] = '{4'b1001, 4'b1000};
        tbl[13] = '{4'b1001, 4'b0001};
        tbl[14] = '{4'b0000, 4'b0000};

        rst_n      = 1'b0;
        req_valid  = 4'b1111;
        reseed_req = 1'b0;
        reseed_val = 32'd0;
        stat_sel   = 2'd2;
        repeat (3) tick();
        check("rst_ready",   {28'd0, req_ready}, 32'd0);
        check("rst_rspv",    {28'd0, rsp_valid}, 32'd0);
        check("rst_data",    rsp_data, 32'd0);
        check("rst_reseed",  {31'd0, gen_re_seed}, 32'd0);
        check("rst_seed",    gen_seed, 32'h1234_5678);
        check("rst_busy",    {31'd0, busy}, 32'd1);
        check("rst_stat",    {16'd0, stat_cnt}, 32'd0);

        // Reset release: pulse on cycle 1, RUN on cycle 3.
        rst_n = 1'b1;
        tick();
        check("rel_pulse",   {31'd0, gen_re_seed}, 32'd1);
        check("rel_seed",    gen_seed, 32'h1234_5678);
        check("rel_busy1",   {31'd0, busy}, 32'd1);
        check("rel_ready1",  {28'd0, req_ready}, 32'd0);
        tick();
        check("rel_pulse2",  {31'd0, gen_re_seed}, 32'd0);
        check("rel_busy2",   {31'd0, busy}, 32'd1);
        check("rel_ready2",  {28'd0, req_ready}, 32'd0);
        req_valid = 4'b0000;
        tick();
        check("rel_busy3",   {31'd0, busy}, 32'd0);

        // Round-robin table.
        exp_data = 32'd0;
        for (int i = 0; i < 15; i++) begin
            req_valid = tbl[i].valid;
            #1;
            check($sformatf("rr_ready[%0d]", i), {28'd0, req_ready}, {28'd0, tbl[i].ready});
            grant_v = tbl[i].ready;
            exp_data = (|grant_v) ? gen_rnd : exp_data;
            tick();
            check($sformatf("rr_rspv[%0d]", i), {28'd0, rsp_valid}, {28'd0, grant_v});
            check($sformatf("rr_data[%0d]", i), rsp_data, exp_data);
        end

        // Reseed collides with requests: reseed wins.
        req_valid  = 4'b1111;
        reseed_req = 1'b1;
        reseed_val = 32'hDEAD_BEEF;
        #1;
        check("collide_ready", {28'd0, req_ready}, 32'd0);
        tick();
        reseed_req = 1'b0;
        check("seed_busy",   {31'd0, busy}, 32'd1);
        check("seed_norsp",  {28'd0, rsp_valid}, 32'd0);
        check("seed_val",    gen_seed, 32'hDEAD_BEEF);
        check("seed_nopulse", {31'd0, gen_re_seed}, 32'd0);
        tick();
        check("seed_pulse",  {31'd0, gen_re_seed}, 32'd1);
        check("settle_ready", {28'd0, req_ready}, 32'd0);
        reseed_req = 1'b1;
        reseed_val = 32'h0000_0BAD;
        tick();
        reseed_req = 1'b0;
        check("settle_ignore", gen_seed, 32'hDEAD_BEEF);
        check("settle_busy", {31'd0, busy}, 32'd1);
        tick();
        check("resume_busy", {31'd0, busy}, 32'd0);
        check("ptr_kept",    {28'd0, req_ready}, 32'h2);
        tick();
        check("db_rspv0",    {28'd0, rsp_valid}, 32'h2);
        check("db_word0",    rsp_data, 32'd1199382711);
        req_valid = 4'b0001;
        #1;
        check("db_ready1",   {28'd0, req_ready}, 32'h1);
        tick();
        check("db_rspv1",    {28'd0, rsp_valid}, 32'h1);
        check("db_word1",    rsp_data, 32'd2384302402);
        exp_word = xs(xs(32'hDEAD_BEEF));
        for (int i = 0; i < 3; i++) begin
            exp_word = xs(exp_word);
            tick();
            check($sformatf("db_stream[%0d]", i), rsp_data, exp_word);
        end

        // Reset mid-RUN with a grant in flight.
        rst_n = 1'b0;
        tick();
        check("rstrun_rspv", {28'd0, rsp_valid}, 32'd0);
        check("rstrun_data", rsp_data, 32'd0);
        check("rstrun_seed", gen_seed, 32'h1234_5678);
        check("rstrun_busy", {31'd0, busy}, 32'd1);
        rst_n     = 1'b1;
        req_valid = 4'b0000;
        wait_run("rstrun_run");

        // Nonzero reseed, then zero reseed falls back to the default.
        reseed_req = 1'b1;
        reseed_val = 32'hCAFE_F00D;
        tick();
        reseed_req = 1'b0;
        check("cafe_seed", gen_seed, 32'hCAFE_F00D);
        wait_run("cafe_run");
        reseed_req = 1'b1;
        reseed_val = 32'd0;
        tick();
        reseed_req = 1'b0;
        check("zero_seed", gen_seed, 32'h1234_5678);
        tick();
        check("zero_pulse", {31'd0, gen_re_seed}, 32'd1);

        // Reset mid-SETTLE restarts at SEED.
        rst_n     = 1'b0;
        req_valid = 4'b1111;
        tick();
        check("rstset_busy",  {31'd0, busy}, 32'd1);
        check("rstset_pulse", {31'd0, gen_re_seed}, 32'd0);
        check("rstset_ready", {28'd0, req_ready}, 32'd0);
        rst_n = 1'b1;
        tick();
        check("rstset_repulse", {31'd0, gen_re_seed}, 32'd1);
        req_valid = 4'b0000;
        wait_run("rstset_run");

        // Statistics.
        req_valid = 4'b0100;
        stat_sel  = 2'd2;
        repeat (3) tick();
`ifdef XORSHIFT32_ARB_STATS_EN
        check("stat_three", {16'd0, stat_cnt}, 32'd3);
        repeat (70000 - 3) tick();
        check("stat_sat", {16'd0, stat_cnt}, 32'h0000_FFFF);
        tick();
        check("stat_hold", {16'd0, stat_cnt}, 32'h0000_FFFF);
        stat_sel = 2'd0;
        #1;
        check("stat_other", {16'd0, stat_cnt}, 32'd0);
`else
        check("stat_off", {16'd0, stat_cnt}, 32'd0);
`endif

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
